mem_initiator: RTL

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_initiator_if.sv | 39 +++
 rtl/mem_initiator_timer.sv | 34 +++
 rtl/mem_initiator.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared bus widths, default timeout, FSM state type and strobe helper
// used by the mem_initiator slice.
package mem_bus_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned STRB_W          = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned TIMER_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    // Reads never present byte enables on the bus, whatever the command carried.
    function automatic logic [STRB_W-1:0] bus_strobe(input logic                write,
                                                     input logic [STRB_W-1:0] wstrb);
        return write ? wstrb : '0;
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// mem_initiator_if: command/response handshake plus memory-bus master signals.
// The master modport is the initiator side, slave is the environment side.
interface mem_initiator_if;
    import mem_bus_pkg::*;

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [STRB_W-1:0] cmd_wstrb_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_error_o;

    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [STRB_W-1:0] mem_wstrb_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        input  rsp_ready_i, mem_ready_i, mem_rdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
        output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        output rsp_ready_i, mem_ready_i, mem_rdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
        input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

endinterface

// File: rtl/mem_initiator_timer.sv
// bus_timeout_timer: counts BUS cycles and flags the cycle that reaches TERMINAL.
// Only built when MEM_INITIATOR_TIMEOUT_EN is defined.
`ifdef MEM_INITIATOR_TIMEOUT_EN
module bus_timeout_timer
    import mem_bus_pkg::*;
#(
    parameter int unsigned TERMINAL = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic clear,
    output logic terminal
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TERMINAL - 1);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    // High during the TERMINAL-th counted cycle, so the owner leaves on that edge.
    assign terminal = start && (count_q == LAST);

endmodule
`endif

// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding command-to-memory-bus initiator, all outputs registered.
// Define MEM_INITIATOR_TIMEOUT_EN to enable the BUS-phase timeout (TIMEOUT_CYCLES).
module mem_initiator
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            resetn,
    mem_initiator_if.master bus
);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              write_q, write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic accept;
    logic in_bus;
    logic timeout_hit;

    assign accept = bus.cmd_valid_i && cmd_ready_q;
    assign in_bus = (state_q == ST_BUS);

`ifdef MEM_INITIATOR_TIMEOUT_EN
    logic terminal;

    bus_timeout_timer #(
        .TERMINAL(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .start   (in_bus),
        .clear   (accept),
        .terminal(terminal)
    );

    assign timeout_hit = terminal;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        write_d     = write_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    state_d     = ST_BUS;
                    cmd_ready_d = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = bus.cmd_addr_i;
                    mem_wdata_d = bus.cmd_wdata_i;
                    mem_wstrb_d = bus_strobe(bus.cmd_write_i, bus.cmd_wstrb_i);
                    write_d     = bus.cmd_write_i;
                end
            end
            ST_BUS: begin
                // Ready is tested first so it wins over a coinciding terminal count.
                if (bus.mem_ready_i) begin
                    state_d     = ST_RESP;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? '0 : bus.mem_rdata_i;
                    rsp_error_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = ST_RESP;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_ready_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.mem_valid_o = mem_valid_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_wstrb_o = mem_wstrb_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_error_o = rsp_error_q;

endmodule
